csa_acc_ctrl: RTL and testbench
===============================

CSA_ACC_CTRL -- requirements
Module: csa_acc_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits.
REQ-002 SHALL have parameter ACC_W, default WIDTH+4, accumulator/result width.
REQ-003 SHALL have a single clock and an asynchronous, active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have start  input  1  one-cycle pulse that begins a new accumulation job.
REQ-005 SHALL have op_count  input  4  number of operands in the job (0..15), sampled on accepted start.
REQ-006 SHALL have in_valid  input  1 and in_ready  output  1: operand handshake.
REQ-007 SHALL have in_data  input  WIDTH  unsigned operand.
REQ-008 SHALL have out_valid  output  1 and out_ready  input  1: result handshake.
REQ-009 SHALL have out_sum  output  ACC_W  resolved sum of all operands in the job.
REQ-010 SHALL have busy  output  1  high in every state except IDLE.

Function
REQ-011 SHALL implement the FSM IDLE -> ACCUM -> RESOLVE -> DONE -> IDLE.
REQ-012 In IDLE, start SHALL clear the sum register S and carry register C, latch op_count, and move to ACCUM on the next edge; start outside IDLE SHALL be ignored.
REQ-013 In ACCUM, in_ready SHALL be 1 while accepted operands < op_count; each in_valid&in_ready cycle SHALL update S <= S^C^X and C <= ((S&C)|(S&X)|(C&X))<<1, with X = in_data zero-extended to ACC_W; one operand per cycle.
REQ-014 When the last operand is accepted, or on entry to ACCUM with op_count=0, the FSM SHALL move to RESOLVE without asserting in_ready for any further operand.
REQ-015 Iterative RESOLVE: if C==0, the FSM SHALL load out_sum <= S and go to DONE; otherwise S <= S^C, C <= (S&C)<<1, and remain in RESOLVE.
REQ-016 All arithmetic SHALL be modulo 2^ACC_W, with the carry shifted out of the MSB dropped; the default widths cannot overflow for 15 operands.
REQ-017 In DONE, out_valid SHALL be 1 and out_sum SHALL be held stable until out_valid&out_ready, after which the FSM SHALL return to IDLE with out_valid=0.
REQ-018 out_sum SHALL retain its last value in IDLE.
REQ-019 A start in the same cycle as the DONE handshake SHALL be ignored.

Reset
REQ-020 rst_n=0 SHALL asynchronously force IDLE, S=C=0, operand counter=0, out_sum=0, in_ready=0, out_valid=0, busy=0, including mid-job; the partial job SHALL be discarded.

Configuration
REQ-021 With CSA_ACC_FAST_RESOLVE_EN defined, RESOLVE SHALL take exactly one cycle: out_sum <= S+C, then DONE.
REQ-022 Without CSA_ACC_FAST_RESOLVE_EN, REQ-015 applies, taking 1..ACC_W+1 cycles; the interface is identical in both builds.

Structure
REQ-023 Package csa_acc_pkg SHALL hold the state enum/encoding and the default WIDTH/ACC_W constants.
REQ-024 The per-bit 3:2 compression SHALL be the sub-module csa_vec (parameter W; inputs a, b, c; outputs sum, carry), instantiated once for the ACCUM update.

Verification
REQ-025 op_count=3, operands 0x0B, 0x0D, 0x06 back-to-back -> out_sum=0x01E, out_valid=1.
REQ-026 op_count=15, all operands 0xFF -> out_sum=0xEF1; in_ready low after the 15th accept.
REQ-027 op_count=0 -> in_ready is never high; out_sum=0x000 with out_valid=1.
REQ-028 out_ready held low 5 cycles after out_valid; start pulsed meanwhile -> out_sum and out_valid stable, start ignored, IDLE reached only after the handshake.
REQ-029 rst_n pulsed low after 2 of 4 operands -> all outputs 0 immediately; a new job (op_count=2, 0x01, 0x02) -> out_sum=0x003.
REQ-030 Operands 0xFF, 0x01 -> out_sum=0x100; RESOLVE lasts 1 cycle with the macro defined, and more than 1 cycle without it.

Source files
------------

// File: rtl/csa_acc_pkg.sv
// Shared definitions for the carry-save accumulator controller: state encoding and default widths.
package csa_acc_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_ACC_W = DEF_WIDTH + 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/csa_acc_ctrl_csa_vec.sv
// Bitwise 3:2 compressor; carry is returned already shifted into its weight position (MSB carry dropped).
module csa_vec #(
  parameter int W = 12
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = ((a & b) | (a & c) | (b & c)) << 1;

endmodule

// File: rtl/csa_acc_ctrl.sv
// Carry-save accumulator: sums op_count unsigned operands in redundant form, then resolves to out_sum.
// Build option: define CSA_ACC_FAST_RESOLVE_EN to resolve with a single-cycle adder instead of ripple iteration.
module csa_acc_ctrl
  import csa_acc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = WIDTH + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             busy
);

  state_t             state_reg, state_next;
  logic [ACC_W-1:0]   s_reg, s_next;
  logic [ACC_W-1:0]   c_reg, c_next;
  logic [ACC_W-1:0]   sum_reg, sum_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic [3:0]         total_reg, total_next;

  logic [ACC_W-1:0]   x_ext;
  logic [ACC_W-1:0]   csa_sum;
  logic [ACC_W-1:0]   csa_carry;
  logic               accept;

  assign x_ext = ACC_W'(in_data);

  csa_vec #(.W(ACC_W)) u_csa (
    .a    (s_reg),
    .b    (c_reg),
    .c    (x_ext),
    .sum  (csa_sum),
    .carry(csa_carry)
  );

  assign in_ready  = (state_reg == ACCUM) && (cnt_reg < total_reg);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign out_sum   = sum_reg;
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      s_reg     <= '0;
      c_reg     <= '0;
      sum_reg   <= '0;
      cnt_reg   <= '0;
      total_reg <= '0;
    end else begin
      state_reg <= state_next;
      s_reg     <= s_next;
      c_reg     <= c_next;
      sum_reg   <= sum_next;
      cnt_reg   <= cnt_next;
      total_reg <= total_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    s_next     = s_reg;
    c_next     = c_reg;
    sum_next   = sum_reg;
    cnt_next   = cnt_reg;
    total_next = total_reg;

    case (state_reg)
      IDLE: begin
        if (start) begin
          s_next     = '0;
          c_next     = '0;
          cnt_next   = '0;
          total_next = op_count;
          state_next = ACCUM;
        end
      end

      ACCUM: begin
        if (accept) begin
          s_next   = csa_sum;
          c_next   = csa_carry;
          cnt_next = cnt_reg + 4'd1;
          if (cnt_reg + 4'd1 == total_reg) state_next = RESOLVE;
        end else if (cnt_reg >= total_reg) begin
          // Only reachable for an empty job.
          state_next = RESOLVE;
        end
      end

      RESOLVE: begin
`ifdef CSA_ACC_FAST_RESOLVE_EN
        sum_next   = s_reg + c_reg;
        state_next = DONE;
`else
        if (c_reg == '0) begin
          sum_next   = s_reg;
          state_next = DONE;
        end else begin
          s_next = s_reg ^ c_reg;
          c_next = (s_reg & c_reg) << 1;
        end
`endif
      end

      DONE: begin
        if (out_ready) state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_csa_acc_ctrl.sv
// Directed, table-driven check of csa_acc_ctrl with hand-computed sums and handshake corner cases.
module tb_csa_acc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  op_count;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  csa_acc_ctrl #(.WIDTH(8), .ACC_W(12)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op_count (op_count),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy)
  );

  typedef struct packed {
    logic [3:0]  n;
    logic [11:0] exp_sum;
    logic [3:0]  hold;
    logic        start_at_hs;
    logic        chk_resolve;
  } vec_t;

  localparam int NV = 7;
  vec_t       tbl[NV];
  logic [7:0] ops_tbl[NV][15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_job(input int vi);
    int idx;
    int guard;
    int rc;
    int extra;
    logic acc;
    logic [11:0] held;
    idx = 0;
    guard = 0;
    @(negedge clk);
    start = 1'b1;
    op_count = tbl[vi].n;
    @(negedge clk);
    start = 1'b0;
    op_count = 4'd0;
    while (idx < int'(tbl[vi].n) && guard < 200) begin
      in_valid = 1'b1;
      in_data  = ops_tbl[vi][idx];
      acc = in_ready;
      @(negedge clk);
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("accepted_count", idx, tbl[vi].n);

    rc = 0;
    extra = 0;
    while (!out_valid && rc < 100) begin
      if (in_ready) extra++;
      @(negedge clk);
      rc++;
    end
    chk("in_ready_after_last", extra, 0);
    chk("out_valid", out_valid, 1);
    chk("out_sum", out_sum, tbl[vi].exp_sum);
    chk("busy_done", busy, 1);
    if (tbl[vi].chk_resolve) begin
`ifdef CSA_ACC_FAST_RESOLVE_EN
      chk("resolve_cycles_fast", rc, 1);
`else
      chk("resolve_cycles_multi", (rc > 1) ? 1 : 0, 1);
`endif
    end

    held = out_sum;
    for (int h = 0; h < int'(tbl[vi].hold); h++) begin
      start = (h == 1);
      op_count = 4'd5;
      @(negedge clk);
      start = 1'b0;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_out_sum", out_sum, held);
    end

    out_ready = 1'b1;
    start = tbl[vi].start_at_hs;
    op_count = 4'd3;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    op_count = 4'd0;
    chk("post_hs_out_valid", out_valid, 0);
    chk("post_hs_busy", busy, 0);
    chk("post_hs_sum_retained", out_sum, tbl[vi].exp_sum);
    $display("job %0d: n=%0d out_sum=0x%0h expected=0x%0h", vi, tbl[vi].n, out_sum, tbl[vi].exp_sum);
  endtask

  initial begin
    for (int i = 0; i < NV; i++)
      for (int j = 0; j < 15; j++)
        ops_tbl[i][j] = 8'h00;

    tbl[0] = '{n: 4'd3,  exp_sum: 12'h01E, hold: 4'd5, start_at_hs: 1'b0, chk_resolve: 1'b0};
    ops_tbl[0][0] = 8'h0B; ops_tbl[0][1] = 8'h0D; ops_tbl[0][2] = 8'h06;
    tbl[1] = '{n: 4'd15, exp_sum: 12'hEF1, hold: 4'd0, start_at_hs: 1'b1, chk_resolve: 1'b0};
    for (int j = 0; j < 15; j++) ops_tbl[1][j] = 8'hFF;
    tbl[2] = '{n: 4'd0,  exp_sum: 12'h000, hold: 4'd2, start_at_hs: 1'b0, chk_resolve: 1'b0};
    tbl[3] = '{n: 4'd2,  exp_sum: 12'h100, hold: 4'd0, start_at_hs: 1'b0, chk_resolve: 1'b1};
    ops_tbl[3][0] = 8'hFF; ops_tbl[3][1] = 8'h01;
    tbl[4] = '{n: 4'd1,  exp_sum: 12'h080, hold: 4'd1, start_at_hs: 1'b1, chk_resolve: 1'b0};
    ops_tbl[4][0] = 8'h80;
    tbl[5] = '{n: 4'd4,  exp_sum: 12'h0A0, hold: 4'd0, start_at_hs: 1'b0, chk_resolve: 1'b0};
    ops_tbl[5][0] = 8'h10; ops_tbl[5][1] = 8'h20; ops_tbl[5][2] = 8'h30; ops_tbl[5][3] = 8'h40;
    tbl[6] = '{n: 4'd2,  exp_sum: 12'h003, hold: 4'd0, start_at_hs: 1'b0, chk_resolve: 1'b0};
    ops_tbl[6][0] = 8'h01; ops_tbl[6][1] = 8'h02;

    rst_n = 1'b0;
    start = 1'b0;
    op_count = 4'd0;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    #12;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_sum", out_sum, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < NV - 1; v++) run_job(v);

    // Abort a 4-operand job after two accepts with an asynchronous reset.
    @(negedge clk);
    start = 1'b1;
    op_count = 4'd4;
    @(negedge clk);
    start = 1'b0;
    begin
      int got;
      int g;
      got = 0;
      g = 0;
      while (got < 2 && g < 50) begin
        in_valid = 1'b1;
        in_data = 8'h55;
        if (in_ready) got++;
        @(negedge clk);
        g++;
      end
      chk("partial_accepts", got, 2);
    end
    in_valid = 1'b0;
    chk("busy_mid_job", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_out_sum", out_sum, 0);
    $display("reset mid-job: busy=%0d out_sum=0x%0h", busy, out_sum);
    @(negedge clk);
    rst_n = 1'b1;

    run_job(NV - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
